// File: rtl/count_mon_pkg.sv
// Shared types and parameter defaults for the count_mon sequence monitor.
package count_mon_pkg;

    localparam int unsigned CNT_W_DEF    = 8;
    localparam int unsigned WRAP_W_DEF   = 16;
    localparam int unsigned ERR_W_DEF    = 8;
    localparam int unsigned RELOCK_N_DEF = 4;

    // Tracking state of the monitored counter stream
    typedef enum logic [1:0] {
        SYNC = 2'd0,
        LOCK = 2'd1,
        MISS = 2'd2
    } state_t;

endpackage

// File: rtl/count_mon_sat_inc.sv
// Width-parameterised saturating increment: holds at all-ones instead of wrapping.
module count_mon_sat_inc #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] i_val,
    input  logic         i_inc,
    output logic [W-1:0] o_next_c
);

    // Increment only when requested and not already at the ceiling
    always_comb begin
        o_next_c = i_val;
        if (i_inc && (i_val != {W{1'b1}})) begin
            o_next_c = i_val + W'(1);
        end
    end

endmodule

// File: rtl/count_mon.sv
// count_mon: watches a free-running counter's output against its enable and
// flags sequence errors, tracks lock state and counts valid rollovers.
// Optional build macro COUNT_MON_HIST_EN adds ERR_EXP/ERR_ACT, which hold the
// expected and actual value of the most recent error.
module count_mon
    import count_mon_pkg::*;
#(
    parameter int unsigned CNT_W    = CNT_W_DEF,
    parameter int unsigned WRAP_W   = WRAP_W_DEF,
    parameter int unsigned ERR_W    = ERR_W_DEF,
    parameter int unsigned RELOCK_N = RELOCK_N_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EN,
    input  logic [CNT_W-1:0]  CNT,
    output logic              LOCKED,
    output logic              ERR,
    output logic [ERR_W-1:0]  ERR_CNT,
    output logic              WRAP,
    output logic [WRAP_W-1:0] WRAP_CNT
`ifdef COUNT_MON_HIST_EN
    ,
    output logic [CNT_W-1:0]  ERR_EXP,
    output logic [CNT_W-1:0]  ERR_ACT
`endif
);

    localparam int unsigned GOOD_W = $clog2(RELOCK_N + 1);

    state_t              r_state;
    state_t              w_next_state;
    logic                r_en_d;
    logic [CNT_W-1:0]    r_cnt_d;
    logic [GOOD_W-1:0]   r_good;
    logic [GOOD_W-1:0]   w_good_inc;
    logic [GOOD_W-1:0]   w_good_next;
    logic [ERR_W-1:0]    w_err_cnt_next;
    logic [CNT_W-1:0]    w_expected;
    logic                w_match;
    logic                w_rollover;
    logic                w_relock;
    logic                w_err;
    logic                w_wrap;

    // Reference for this sample, built from the previous cycle's enable and value
    always_comb begin
        w_expected = r_en_d ? (r_cnt_d + CNT_W'(1)) : r_cnt_d;
        w_match    = (CNT == w_expected);
        w_rollover = r_en_d && (r_cnt_d == {CNT_W{1'b1}}) && (CNT == '0);
        w_relock   = w_match && (w_good_inc == GOOD_W'(RELOCK_N));
    end

    count_mon_sat_inc #(
        .W (GOOD_W)
    ) u_good_inc (
        .i_val    (r_good),
        .i_inc    (1'b1),
        .o_next_c (w_good_inc)
    );

    count_mon_sat_inc #(
        .W (ERR_W)
    ) u_err_inc (
        .i_val    (ERR_CNT),
        .i_inc    (w_err),
        .o_next_c (w_err_cnt_next)
    );

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= SYNC;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            SYNC:    w_next_state = LOCK;
            LOCK:    if (!w_match) w_next_state = MISS;
            MISS:    if (w_relock) w_next_state = LOCK;
            default: w_next_state = SYNC;
        endcase
    end

    // Per-state event decode; the first sample after reset is only captured
    always_comb begin
        w_err       = 1'b0;
        w_wrap      = 1'b0;
        w_good_next = r_good;
        case (r_state)
            LOCK: begin
                w_err       = !w_match;
                w_wrap      = w_match && w_rollover;
                w_good_next = '0;
            end
            MISS: begin
                w_err  = !w_match;
                w_wrap = w_match && w_rollover;
                if (!w_match || w_relock) begin
                    w_good_next = '0;
                end else begin
                    w_good_next = w_good_inc;
                end
            end
            default: begin
                w_err       = 1'b0;
                w_wrap      = 1'b0;
                w_good_next = '0;
            end
        endcase
    end

    // Sample pipeline, counters and registered outputs; reference always follows CNT
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_en_d   <= 1'b0;
            r_cnt_d  <= '0;
            r_good   <= '0;
            LOCKED   <= 1'b0;
            ERR      <= 1'b0;
            WRAP     <= 1'b0;
            ERR_CNT  <= '0;
            WRAP_CNT <= '0;
        end else begin
            r_en_d   <= EN;
            r_cnt_d  <= CNT;
            r_good   <= w_good_next;
            LOCKED   <= (w_next_state == LOCK);
            ERR      <= w_err;
            WRAP     <= w_wrap;
            ERR_CNT  <= w_err_cnt_next;
            if (w_wrap) begin
                WRAP_CNT <= WRAP_CNT + WRAP_W'(1);
            end
        end
    end

`ifdef COUNT_MON_HIST_EN
    // Capture expected/actual of the most recent error
    always_ff @(posedge CLK) begin
        if (RST) begin
            ERR_EXP <= '0;
            ERR_ACT <= '0;
        end else if (w_err) begin
            ERR_EXP <= w_expected;
            ERR_ACT <= CNT;
        end
    end
`endif

endmodule

// File: tb/tb_count_mon.sv
// Self-checking bench for count_mon (default parameters).
module tb_count_mon;

    logic        CLK = 1'b0;
    logic        RST;
    logic        EN;
    logic [7:0]  CNT;
    logic        LOCKED;
    logic        ERR;
    logic [7:0]  ERR_CNT;
    logic        WRAP;
    logic [15:0] WRAP_CNT;
`ifdef COUNT_MON_HIST_EN
    logic [7:0]  ERR_EXP;
    logic [7:0]  ERR_ACT;
`endif

    count_mon dut (
        .CLK      (CLK),
        .RST      (RST),
        .EN       (EN),
        .CNT      (CNT),
        .LOCKED   (LOCKED),
        .ERR      (ERR),
        .ERR_CNT  (ERR_CNT),
        .WRAP     (WRAP),
        .WRAP_CNT (WRAP_CNT)
`ifdef COUNT_MON_HIST_EN
        ,
        .ERR_EXP  (ERR_EXP),
        .ERR_ACT  (ERR_ACT)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        locked;
        logic        err;
        logic        wrap;
        logic [7:0]  err_cnt;
        logic [15:0] wrap_cnt;
    } obs_t;

    obs_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model state (0 = sync, 1 = lock, 2 = miss)
    int          m_state = 0;
    int          m_good = 0;
    logic        m_en_d = 1'b0;
    logic [7:0]  m_cnt_d = 8'd0;
    int          m_err_cnt = 0;
    int          m_wrap_cnt = 0;
    logic [7:0]  m_err_exp = 8'd0;
    logic [7:0]  m_err_act = 8'd0;
    logic [7:0]  tb_cnt;

    function automatic obs_t obs();
        obs_t o;
        o.locked   = LOCKED;
        o.err      = ERR;
        o.wrap     = WRAP;
        o.err_cnt  = ERR_CNT;
        o.wrap_cnt = WRAP_CNT;
        return o;
    endfunction

    // Advance the behavioural model by one clock edge and queue what the DUT should show
    task automatic model_edge(input logic rst, input logic en, input logic [7:0] cnt);
        obs_t       e;
        logic [7:0] want;
        e = '0;
        if (rst) begin
            m_state = 0; m_good = 0; m_en_d = 1'b0; m_cnt_d = 8'd0;
            m_err_cnt = 0; m_wrap_cnt = 0; m_err_exp = 8'd0; m_err_act = 8'd0;
        end else begin
            want = m_en_d ? 8'(m_cnt_d + 8'd1) : m_cnt_d;
            if (m_state == 0) begin
                m_state = 1;
            end else if (cnt != want) begin
                e.err = 1'b1;
                if (m_err_cnt < 255) m_err_cnt = m_err_cnt + 1;
                m_err_exp = want;
                m_err_act = cnt;
                m_good = 0;
                m_state = 2;
            end else begin
                if (m_en_d && m_cnt_d == 8'hFF && cnt == 8'h00) begin
                    e.wrap = 1'b1;
                    m_wrap_cnt = (m_wrap_cnt + 1) % 65536;
                end
                if (m_state == 2) begin
                    m_good = m_good + 1;
                    if (m_good == 4) begin
                        m_state = 1;
                        m_good = 0;
                    end
                end
            end
            m_en_d = en;
            m_cnt_d = cnt;
        end
        e.locked   = (m_state == 1);
        e.err_cnt  = 8'(m_err_cnt);
        e.wrap_cnt = 16'(m_wrap_cnt);
        sb_q.push_back(e);
    endtask

    // Drive one cycle of stimulus, record expectation, and land #1 after the edge
    task automatic drive(input logic rst, input logic en, input logic [7:0] cnt);
        RST = rst;
        EN  = en;
        CNT = cnt;
        model_edge(rst, en, cnt);
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        obs_t e, g;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 8'd0);
            e = sb_q.pop_front(); g = obs(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL reset_sb step %0d: got %h want %h", i, g, e);
            end
        end
        checks++;
        if (LOCKED !== 1'b0 || ERR !== 1'b0 || WRAP !== 1'b0 || ERR_CNT !== 8'd0 || WRAP_CNT !== 16'd0) begin
            errors++;
            $display("FAIL reset_outputs: got locked=%b err=%b wrap=%b err_cnt=%0d wrap_cnt=%0d want all 0",
                     LOCKED, ERR, WRAP, ERR_CNT, WRAP_CNT);
        end
    endtask

    task automatic test_clean_run();
        obs_t e, g;
        int   wraps = 0, errs = 0, wrap_at = -1;
        tb_cnt = 8'd0;
        for (int i = 0; i < 270; i++) begin
            drive(1'b0, 1'b1, tb_cnt);
            tb_cnt = tb_cnt + 8'd1;
            e = sb_q.pop_front(); g = obs(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL clean_sb step %0d: got %h want %h", i, g, e);
            end
            if (WRAP === 1'b1) begin wraps++; wrap_at = i; end
            if (ERR === 1'b1) errs++;
            if (i == 0) begin
                checks++;
                if (LOCKED !== 1'b1) begin
                    errors++;
                    $display("FAIL clean_first_lock: got %b want 1", LOCKED);
                end
            end
        end
        checks++;
        if (wraps != 1 || wrap_at != 256) begin
            errors++;
            $display("FAIL clean_wrap_pulse: got count=%0d at=%0d want count=1 at=256", wraps, wrap_at);
        end
        checks++;
        if (WRAP_CNT !== 16'd1 || ERR_CNT !== 8'd0 || errs != 0) begin
            errors++;
            $display("FAIL clean_counters: got wrap_cnt=%0d err_cnt=%0d err_pulses=%0d want 1 0 0",
                     WRAP_CNT, ERR_CNT, errs);
        end
    endtask

    task automatic test_en_hold();
        obs_t e, g;
        int   errs = 0, unlocked = 0;
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'b0, tb_cnt);
            e = sb_q.pop_front(); g = obs(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL hold_sb step %0d: got %h want %h", i, g, e);
            end
            if (ERR !== 1'b0) errs++;
            if (LOCKED !== 1'b1) unlocked++;
        end
        checks++;
        if (errs != 0 || unlocked != 0 || ERR_CNT !== 8'd0) begin
            errors++;
            $display("FAIL hold_quiet: got err_pulses=%0d unlocked=%0d err_cnt=%0d want 0 0 0",
                     errs, unlocked, ERR_CNT);
        end
    endtask

    task automatic test_glitch();
        obs_t       e, g;
        logic [7:0] seq [0:8];
        int         lows = 0, errs = 0;
        seq = '{8'd8, 8'd9, 8'd10, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16, 8'd17};
        drive(1'b1, 1'b0, 8'd0);
        e = sb_q.pop_front(); g = obs(); checks++;
        if (g !== e) begin errors++; $display("FAIL glitch_rst_sb: got %h want %h", g, e); end
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, seq[i]);
            e = sb_q.pop_front(); g = obs(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL glitch_sb step %0d: got %h want %h", i, g, e);
            end
            if (i == 3) begin
                checks++;
                if (ERR !== 1'b1 || ERR_CNT !== 8'd1 || LOCKED !== 1'b0) begin
                    errors++;
                    $display("FAIL glitch_hit: got err=%b err_cnt=%0d locked=%b want 1 1 0", ERR, ERR_CNT, LOCKED);
                end
`ifdef COUNT_MON_HIST_EN
                checks++;
                if (ERR_EXP !== 8'd11 || ERR_ACT !== 8'd12) begin
                    errors++;
                    $display("FAIL glitch_hist: got exp=%0d act=%0d want 11 12", ERR_EXP, ERR_ACT);
                end
`endif
            end
            if (i > 3) begin
                if (LOCKED !== 1'b1) lows++;
                if (ERR !== 1'b0) errs++;
            end
        end
        checks++;
        if (lows != 3 || errs != 0 || LOCKED !== 1'b1 || ERR_CNT !== 8'd1) begin
            errors++;
            $display("FAIL glitch_relock: got lows_after=%0d extra_err=%0d locked=%b err_cnt=%0d want 3 0 1 1",
                     lows, errs, LOCKED, ERR_CNT);
        end
        tb_cnt = seq[8];
    endtask

    task automatic test_en_low_change();
        obs_t e, g;
        drive(1'b0, 1'b0, tb_cnt);
        e = sb_q.pop_front(); g = obs(); checks++;
        if (g !== e || ERR !== 1'b0) begin
            errors++;
            $display("FAIL enlow_hold: got %h want %h", g, e);
        end
        drive(1'b0, 1'b0, tb_cnt + 8'd2);
        e = sb_q.pop_front(); g = obs(); checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL enlow_sb: got %h want %h", g, e);
        end
        checks++;
        if (ERR !== 1'b1 || ERR_CNT !== 8'd2 || LOCKED !== 1'b0) begin
            errors++;
            $display("FAIL enlow_change: got err=%b err_cnt=%0d locked=%b want 1 2 0", ERR, ERR_CNT, LOCKED);
        end
`ifdef COUNT_MON_HIST_EN
        checks++;
        if (ERR_EXP !== m_err_exp || ERR_ACT !== m_err_act) begin
            errors++;
            $display("FAIL enlow_hist: got exp=%0d act=%0d want %0d %0d", ERR_EXP, ERR_ACT, m_err_exp, m_err_act);
        end
`endif
    endtask

    task automatic test_saturate();
        obs_t e, g;
        int   pulses = 0;
        for (int i = 0; i < 300; i++) begin
            drive(1'b0, 1'b1, 8'h55);
            e = sb_q.pop_front(); g = obs(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL sat_sb step %0d: got %h want %h", i, g, e);
            end
            if (ERR === 1'b1) pulses++;
        end
        checks++;
        if (ERR_CNT !== 8'd255 || LOCKED !== 1'b0 || pulses != 300) begin
            errors++;
            $display("FAIL sat_hold: got err_cnt=%0d locked=%b pulses=%0d want 255 0 300", ERR_CNT, LOCKED, pulses);
        end
    endtask

    task automatic test_reset_mid();
        obs_t       e, g;
        logic [7:0] seq [0:5];
        seq = '{8'd0, 8'd0, 8'd1, 8'd5, 8'd5, 8'd5};
        for (int i = 0; i < 6; i++) begin
            drive(i == 0, i != 0, seq[i]);
            e = sb_q.pop_front(); g = obs(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL rmid_setup_sb step %0d: got %h want %h", i, g, e);
            end
        end
        checks++;
        if (ERR_CNT !== 8'd3 || LOCKED !== 1'b0 || ERR !== 1'b1) begin
            errors++;
            $display("FAIL rmid_miss: got err_cnt=%0d locked=%b err=%b want 3 0 1", ERR_CNT, LOCKED, ERR);
        end
        drive(1'b1, 1'b1, 8'd9);
        e = sb_q.pop_front(); g = obs(); checks++;
        if (g !== e || g !== obs_t'(0)) begin
            errors++;
            $display("FAIL rmid_reset: got %h want %h", g, e);
        end
`ifdef COUNT_MON_HIST_EN
        checks++;
        if (ERR_EXP !== 8'd0 || ERR_ACT !== 8'd0) begin
            errors++;
            $display("FAIL rmid_hist: got exp=%0d act=%0d want 0 0", ERR_EXP, ERR_ACT);
        end
`endif
        drive(1'b0, 1'b1, 8'd7);
        e = sb_q.pop_front(); g = obs(); checks++;
        if (g !== e || LOCKED !== 1'b1 || ERR !== 1'b0) begin
            errors++;
            $display("FAIL rmid_relock: got %h want %h", g, e);
        end
        drive(1'b0, 1'b1, 8'd8);
        e = sb_q.pop_front(); g = obs(); checks++;
        if (g !== e || LOCKED !== 1'b1 || ERR_CNT !== 8'd0) begin
            errors++;
            $display("FAIL rmid_track: got %h want %h", g, e);
        end
    endtask

    initial begin
        RST = 1'b1;
        EN  = 1'b0;
        CNT = 8'd0;
        test_reset();
        test_clean_run();
        test_en_hold();
        test_glitch();
        test_en_low_change();
        test_saturate();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/count_mon.md
COUNT_MON -- requirements
Module: count_mon

Interface
REQ-001 Parameter CNT_W, default 8, width of the monitored counter value.
REQ-002 Parameter WRAP_W, default 16, width of the wrap-event counter.
REQ-003 Parameter ERR_W, default 8, width of the saturating error counter.
REQ-004 Parameter RELOCK_N, default 4, consecutive good samples required to regain lock.
REQ-005 CLK  input  1  sole clock, all state updates on rising edge.
REQ-006 RST  input  1  synchronous reset, active-high.
REQ-007 EN  input  1  enable presented to the monitored counter in the same cycle.
REQ-008 CNT  input  CNT_W  registered output of the monitored counter.
REQ-009 LOCKED  output  1  high while the stream is tracked without recent error.
REQ-010 ERR  output  1  one-cycle pulse per detected sequence error.
REQ-011 ERR_CNT  output  ERR_W  number of errors since reset, saturating.
REQ-012 WRAP  output  1  one-cycle pulse per valid max-to-0 rollover.
REQ-013 WRAP_CNT  output  WRAP_W  number of rollovers since reset, modulo 2^WRAP_W.

Function
REQ-014 Module SHALL register EN and CNT every cycle as EN_D/CNT_D; expected value = EN_D ? (CNT_D+1) mod 2^CNT_W : CNT_D.
REQ-015 States SHALL be SYNC, LOCK, MISS; LOCKED SHALL equal (state==LOCK), registered.
REQ-016 SYNC: first cycle after reset release captures the sample with no comparison, then moves to LOCK.
REQ-017 LOCK: CNT==expected keeps LOCK; mismatch moves to MISS, clears the good-sample counter.
REQ-018 MISS: match increments the good-sample counter; reaching RELOCK_N moves to LOCK; mismatch clears it and stays in MISS.
REQ-019 Every mismatch in LOCK or MISS SHALL pulse ERR and increment ERR_CNT, holding at 2^ERR_W-1.
REQ-020 WRAP SHALL pulse and WRAP_CNT increment when EN_D=1, CNT_D=2^CNT_W-1, CNT==0, in LOCK or MISS; wrap does not count in SYNC.
REQ-021 Reference SHALL always resync to the actual CNT sample, so one glitch yields exactly one error.
REQ-022 ERR, WRAP, LOCKED, ERR_CNT, WRAP_CNT SHALL update one cycle after the CNT sample that causes them.
REQ-023 EN low with CNT unchanged SHALL be a match; CNT changing while EN_D low SHALL be an error.
REQ-024 ERR and WRAP SHALL never assert in the same cycle.

Reset
REQ-025 RST high SHALL force state SYNC, LOCKED=0, ERR=0, WRAP=0, ERR_CNT=0, WRAP_CNT=0, good-sample counter=0, EN_D=0, CNT_D=0.
REQ-026 RST asserted mid-operation SHALL take effect at the next edge regardless of state; no pulse SHALL be emitted that cycle.

Configuration
REQ-027 Macro COUNT_MON_HIST_EN defined SHALL add outputs ERR_EXP and ERR_ACT (CNT_W each) holding expected/actual of the latest error, reset 0.
REQ-028 Macro undefined SHALL omit those ports and registers; all other behaviour identical.

Structure
REQ-029 Package count_mon_pkg SHALL hold the state enum (SYNC/LOCK/MISS) and the parameter defaults.
REQ-030 Sub-module count_mon_sat_inc SHALL implement the width-parameterised saturating increment used by ERR_CNT and the good-sample counter.

Verification
REQ-031 RST 3 cycles, then EN=1, clean counter 270 cycles -> LOCKED=1 from 2nd cycle after release, one WRAP at 255->0, WRAP_CNT=1, ERR_CNT=0.
REQ-032 EN=0 for 20 cycles with CNT held at 14 -> no ERR, LOCKED stays 1.
REQ-033 Force CNT 10->12 with EN=1 -> ERR one cycle, ERR_CNT=1, LOCKED=0 for 4 good samples then 1; HIST_EN build: ERR_EXP=11, ERR_ACT=12.
REQ-034 300 consecutive mismatches -> ERR_CNT=255 and holds; state stays MISS.
REQ-035 RST pulsed while in MISS with ERR_CNT=3 -> all outputs 0 next cycle, SYNC, relocks on next clean sample.
